rv32i_lsu: RTL and testbench

Load/store unit between the rv32i execute stage and the word-organised data `ram`. It accepts one RV32I load or store per transaction and converts it into word accesses on the RAM's `addr`/`wdata`/`mem_op`/`rdata` ports:
- loads: byte/half extraction with sign or zero extension;
- sub-word stores: read-modify-write;
- misaligned or illegal requests: rejected with an error response.

---
 rtl/rv32i_pkg.sv | 34 +++
 rtl/rv32i_lsu_align.sv | 44 ++++
 rtl/rv32i_lsu.sv | 135 +++++++++++++
 tb/tb_rv32i_lsu.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_pkg.sv
// Shared rv32i definitions: RAM operation codes, load/store funct3 encodings
// and the request legality rule used by the load/store unit.
package rv32i_pkg;

  typedef enum logic [1:0] {
    MEM_NONE  = 2'd0,
    MEM_LOAD  = 2'd1,
    MEM_STORE = 2'd2
  } mem_op_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Unsigned variants exist only for loads, and halves/words must be naturally aligned.
  function automatic logic req_is_err(input logic       we,
                                      input logic [2:0] funct3,
                                      input logic [1:0] addr_lo);
    logic err;
    err = 1'b1;
    case (funct3)
      F3_B:    err = 1'b0;
      F3_H:    err = addr_lo[0];
      F3_W:    err = (addr_lo != 2'b00);
      F3_BU:   err = we;
      F3_HU:   err = we | addr_lo[0];
      default: err = 1'b1;
    endcase
    return err;
  endfunction

endpackage

// File: rtl/rv32i_lsu_align.sv
// Byte-lane steering for the LSU: load extract/extend and sub-word store merge.
// Only the low half of the store data can ever land in a lane, so only that
// half is brought in.
module lsu_align
  import rv32i_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] word,
  input  logic [15:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] store_word
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  // Pick the addressed byte/half out of the RAM word and extend it.
  always_comb begin
    lane_b = word[{addr_lo, 3'b000} +: 8];
    lane_h = addr_lo[1] ? word[31:16] : word[15:0];
    case (funct3)
      F3_B:    load_data = {{24{lane_b[7]}}, lane_b};
      F3_H:    load_data = {{16{lane_h[15]}}, lane_h};
      F3_BU:   load_data = {24'd0, lane_b};
      F3_HU:   load_data = {16'd0, lane_h};
      default: load_data = word;
    endcase
  end

  // Replace the addressed lane(s) of the old word with the store data.
  always_comb begin
    store_word = word;
    case (funct3)
      F3_B: store_word[{addr_lo, 3'b000} +: 8] = wdata[7:0];
      F3_H: begin
        if (addr_lo[1]) store_word[31:16] = wdata;
        else            store_word[15:0]  = wdata;
      end
      default: store_word = word;
    endcase
  end

endmodule

// File: rtl/rv32i_lsu.sv
// RV32I load/store unit: turns one load/store request into word accesses on
// the data RAM, with read-modify-write for sub-word stores.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// IDLE      | ready for a request; accept drives RAM address/op directly
// LOAD_RD   | RAM word arriving; extract/extend into resp_rdata
// STORE_RMW | old word arriving; write back with merged lane(s)
// RESP      | one-cycle response pulse
module rv32i_lsu
  import rv32i_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  output mem_op_e     ram_mem_op,
  input  logic [31:0] ram_rdata
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOAD_RD   = 2'd1,
    STORE_RMW = 2'd2,
    RESP      = 2'd3
  } lsu_state_e;

  lsu_state_e  state, next_state;
  logic [2:0]  lat_funct3;
  logic [31:0] lat_addr;
  logic [15:0] lat_wdata;
  logic        req_err;
  logic        accept;
  logic        resp_now;
  logic [31:0] load_data;
  logic [31:0] store_word;

  assign req_err    = req_is_err(req_we, req_funct3, req_addr[1:0]);
  assign accept     = (state == IDLE) && req_valid;
  // Errors and SW complete without a RAM read, so their response is known at accept.
  assign resp_now   = req_err || (req_we && (req_funct3 == F3_W));
  assign resp_valid = rst_n && (state == RESP);

  lsu_align u_align (
    .funct3     (lat_funct3),
    .addr_lo    (lat_addr[1:0]),
    .word       (ram_rdata),
    .wdata      (lat_wdata),
    .load_data  (load_data),
    .store_word (store_word)
  );

  // State, latched request and the held response registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      lat_funct3 <= '0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      state <= next_state;
      if (accept) begin
        lat_funct3 <= req_funct3;
        lat_addr   <= req_addr;
        lat_wdata  <= req_wdata[15:0];
        if (resp_now) begin
          resp_rdata <= '0;
          resp_err   <= req_err;
        end
      end
      if (state == LOAD_RD) begin
        resp_rdata <= load_data;
        resp_err   <= 1'b0;
      end
      if (state == STORE_RMW) begin
        resp_rdata <= '0;
        resp_err   <= 1'b0;
      end
    end
  end

  // Next state and RAM drive; reset forces the RAM idle so an in-flight RMW never writes.
  always_comb begin
    next_state = state;
    req_ready  = 1'b0;
    ram_mem_op = MEM_NONE;
    ram_addr   = lat_addr;
    ram_wdata  = '0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          ram_addr = req_addr;
          if (req_err) begin
            next_state = RESP;
          end else if (!req_we) begin
            ram_mem_op = MEM_LOAD;
            next_state = LOAD_RD;
          end else if (req_funct3 == F3_W) begin
            ram_mem_op = MEM_STORE;
            ram_wdata  = req_wdata;
            next_state = RESP;
          end else begin
            ram_mem_op = MEM_LOAD;
            next_state = STORE_RMW;
          end
        end
      end
      LOAD_RD: next_state = RESP;
      STORE_RMW: begin
        ram_mem_op = MEM_STORE;
        ram_wdata  = store_word;
        next_state = RESP;
      end
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
    if (!rst_n) begin
      req_ready  = 1'b0;
      ram_mem_op = MEM_NONE;
    end
  end

endmodule

// File: tb/tb_rv32i_lsu.sv
// Testbench for rv32i_lsu: word RAM model, scoreboard of expected responses
// from a byte/mask-level memory model, directed cases plus random traffic.
module tb_rv32i_lsu;
  import rv32i_pkg::*;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
    logic [31:0] lat;
    logic [31:0] acc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] ram_addr;
  logic [31:0] ram_wdata;
  mem_op_e     ram_mem_op;
  logic [31:0] ram_rdata = 32'd0;

  logic [31:0] ram_mem   [4096];
  logic [31:0] model_mem [4096];
  exp_t        exp_q [$];
  exp_t        mon_e;

  int cyc = 0;
  int errors = 0;
  int checks = 0;
  int n_issued = 0;
  int n_manual = 0;
  int n_resp = 0;
  int n_acc = 0;
  int n_ram_writes = 0;
  int n_exp_writes = 0;

  always #5 clk = ~clk;

  rv32i_lsu dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .ram_addr   (ram_addr),
    .ram_wdata  (ram_wdata),
    .ram_mem_op (ram_mem_op),
    .ram_rdata  (ram_rdata)
  );

  // Word RAM: registered read, write on MEM_STORE, index addr[13:2].
  always @(posedge clk) begin
    if (ram_mem_op == MEM_STORE) ram_mem[ram_addr[13:2]] <= ram_wdata;
    ram_rdata <= ram_mem[ram_addr[13:2]];
  end

  always @(posedge clk) begin
    cyc++;
    if (ram_mem_op == MEM_STORE) n_ram_writes++;
    if (req_valid && req_ready) n_acc++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Reference: memory as an array of words, lanes handled with shifts and masks.
  function automatic exp_t model(input logic we, input logic [2:0] f3,
                                 input logic [31:0] addr, input logic [31:0] wd);
    exp_t        e;
    logic        legal;
    int          idx;
    int          sh;
    logic [31:0] w;
    logic [31:0] s;
    logic [31:0] mask;
    e = '0;
    case (f3)
      3'd0:    legal = 1'b1;
      3'd1:    legal = (addr[0] == 1'b0);
      3'd2:    legal = (addr[1:0] == 2'b00);
      3'd4:    legal = !we;
      3'd5:    legal = !we && (addr[0] == 1'b0);
      default: legal = 1'b0;
    endcase
    if (!legal) begin
      e.err = 1'b1;
      e.lat = 32'd1;
      return e;
    end
    idx = int'(addr[13:2]);
    sh  = int'(addr[1:0]) * 8;
    w   = model_mem[idx];
    s   = w >> sh;
    if (!we) begin
      e.lat = 32'd2;
      case (f3)
        3'd0:    e.rdata = {{24{s[7]}}, s[7:0]};
        3'd1:    e.rdata = {{16{s[15]}}, s[15:0]};
        3'd4:    e.rdata = s & 32'h0000_00FF;
        3'd5:    e.rdata = s & 32'h0000_FFFF;
        default: e.rdata = w;
      endcase
    end else begin
      n_exp_writes++;
      if (f3 == 3'd2) begin
        model_mem[idx] = wd;
        e.lat = 32'd1;
      end else begin
        mask = (f3 == 3'd0) ? 32'h0000_00FF : 32'h0000_FFFF;
        mask = mask << sh;
        model_mem[idx] = (w & ~mask) | ((wd << sh) & mask);
        e.lat = 32'd2;
      end
    end
    return e;
  endfunction

  task automatic wait_ready(output logic ok);
    int waited = 0;
    ok = 1'b1;
    @(negedge clk);
    while (req_ready !== 1'b1) begin
      if (waited == 50) begin
        fail_now("req_ready timeout");
        ok = 1'b0;
        return;
      end
      @(negedge clk);
      waited++;
    end
  endtask

  // Present a request in an IDLE cycle; req_valid stays high afterwards.
  task automatic issue(input logic we, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wd);
    exp_t e;
    logic ok;
    wait_ready(ok);
    if (!ok) return;
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wd;
    e     = model(we, f3, addr, wd);
    e.acc = 32'(cyc);
    exp_q.push_back(e);
    n_issued++;
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  // Monitor: every response pulse is matched against the oldest expectation.
  always @(negedge clk) begin
    if (resp_valid === 1'b1) begin
      n_resp++;
      if (exp_q.size() == 0) begin
        fail_now("unexpected resp_valid");
      end else begin
        mon_e = exp_q.pop_front();
        chk("resp_rdata", resp_rdata, mon_e.rdata);
        chk("resp_err", 32'(resp_err), 32'(mon_e.err));
        chk("latency", 32'(cyc) - mon_e.acc, mon_e.lat);
        chk("req_ready in RESP", 32'(req_ready), 32'd0);
      end
    end
  end

  initial begin
    logic        ok;
    logic [31:0] r32;
    logic [2:0]  legal_f3 [8];
    int          waited;

    legal_f3 = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd0, 3'd1, 3'd2};
    for (int i = 0; i < 4096; i++) begin
      r32 = $urandom;
      ram_mem[i]   = r32;
      model_mem[i] = r32;
    end

    // Reset behaviour
    repeat (3) @(negedge clk);
    chk("rst req_ready", 32'(req_ready), 32'd0);
    chk("rst ram_mem_op", 32'(ram_mem_op), 32'(MEM_NONE));
    chk("rst resp_valid", 32'(resp_valid), 32'd0);
    chk("rst resp_rdata", resp_rdata, 32'd0);
    chk("rst resp_err", 32'(resp_err), 32'd0);
    chk("rst ram_addr", ram_addr, 32'd0);
    chk("rst ram_wdata", ram_wdata, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready after reset", 32'(req_ready), 32'd1);

    // SW then LW
    issue(1'b1, F3_W, 32'h10, 32'hDEADBEEF);
    issue(1'b0, F3_W, 32'h10, 32'h0);
    idle_cycle();

    // Sign/zero extension
    issue(1'b1, F3_W, 32'h20, 32'h80FF7F01);
    issue(1'b0, F3_B, 32'h21, 32'h0);
    issue(1'b0, F3_B, 32'h23, 32'h0);
    issue(1'b0, F3_BU, 32'h23, 32'h0);
    issue(1'b0, F3_H, 32'h22, 32'h0);
    issue(1'b0, F3_HU, 32'h22, 32'h0);
    idle_cycle();

    // Read-modify-write
    issue(1'b1, F3_W, 32'h30, 32'h11223344);
    issue(1'b1, F3_B, 32'h31, 32'h000000AA);
    issue(1'b1, F3_H, 32'h32, 32'h0000BBCC);
    issue(1'b0, F3_W, 32'h30, 32'h0);
    idle_cycle();
    chk("rmw model word", model_mem[12], 32'hBBCCAA44);

    // Errors, then confirm the word was left alone
    issue(1'b0, F3_H, 32'h41, 32'h0);
    issue(1'b0, F3_W, 32'h42, 32'h0);
    issue(1'b1, F3_W, 32'h43, 32'h55555555);
    issue(1'b0, 3'b011, 32'h40, 32'h0);
    issue(1'b1, F3_BU, 32'h40, 32'h12345678);
    issue(1'b1, F3_H, 32'h41, 32'h12345678);
    issue(1'b0, F3_W, 32'h40, 32'h0);
    idle_cycle();

    // Reset while in STORE_RMW suppresses the write and the response
    wait_ready(ok);
    if (ok) begin
      req_valid  = 1'b1;
      req_we     = 1'b1;
      req_funct3 = F3_B;
      req_addr   = 32'h51;
      req_wdata  = 32'h000000EE;
      n_manual++;
      @(negedge clk);
      req_valid = 1'b0;
      chk("rmw store phase", 32'(ram_mem_op), 32'(MEM_STORE));
      rst_n = 1'b0;
      @(negedge clk);
      chk("mid-reset req_ready", 32'(req_ready), 32'd0);
      chk("mid-reset ram_mem_op", 32'(ram_mem_op), 32'(MEM_NONE));
      chk("mid-reset resp_rdata", resp_rdata, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("ready after release", 32'(req_ready), 32'd1);
    end
    issue(1'b0, F3_W, 32'h50, 32'h0);
    idle_cycle();

    // Continuous req_valid with alternating SW/LW
    for (int i = 0; i < 16; i++) begin
      r32 = $urandom;
      issue(1'b1, F3_W, 32'h100 + 32'(i * 4), r32);
      issue(1'b0, F3_W, 32'h100 + 32'(i * 4), 32'h0);
    end
    idle_cycle();

    // Random traffic over 64 words with random upper address bits
    for (int i = 0; i < 400; i++) begin
      logic        we;
      logic [2:0]  f3;
      logic [31:0] addr;
      r32  = $urandom;
      we   = r32[0];
      f3   = (r32[4:1] < 4'd13) ? legal_f3[r32[7:5]] : r32[10:8];
      r32  = $urandom;
      addr = r32 & 32'hFFFF_C0FF;
      issue(we, f3, addr, $urandom);
      if ($urandom_range(0, 2) == 0) idle_cycle();
    end
    idle_cycle();

    // Drain
    waited = 0;
    while (exp_q.size() != 0 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (exp_q.size() != 0) fail_now("responses outstanding at end");
    repeat (3) @(negedge clk);

    chk("response count", 32'(n_resp), 32'(n_issued));
    chk("accept count", 32'(n_acc), 32'(n_issued + n_manual));
    chk("ram write count", 32'(n_ram_writes), 32'(n_exp_writes));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
